ram_rd_streamer: RTL and testbench

Read-side command engine for the byte-enable simple dual-port RAM. It accepts an (address, length) read command and drives the RAM read port (registered read, 1-cycle latency, no read enable). It returns the words in order as a valid/ready stream with a last flag. A 2-entry skid buffer absorbs the RAM latency, so the block sustains one word per cycle under no backpressure and loses no data under arbitrary backpressure.

---
 rtl/ram_rd_streamer.sv | 127 ++++++++++++
 tb/tb_ram_rd_streamer.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_rd_streamer.sv
// Read command engine for a simple dual-port RAM with a registered read port.
// Streams (addr, len) bursts out as valid/ready beats through a 2-entry skid buffer.
module ram_rd_streamer #(
    parameter int  WORD_WIDTH = 32,
    parameter int  WORD_COUNT = 256,
    localparam int ADDR_WIDTH = $clog2(WORD_COUNT),
    localparam int LEN_WIDTH  = ADDR_WIDTH + 1
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
    input  logic [LEN_WIDTH-1:0]  cmd_len_i,
    output logic [ADDR_WIDTH-1:0] ram_addr_o,
    input  logic [WORD_WIDTH-1:0] ram_rdata_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [WORD_WIDTH-1:0] out_data_o,
    output logic                  out_last_o,
    output logic                  busy_o,
    output logic                  done_o
);

    typedef enum logic {
        S_IDLE,
        S_RUN
    } state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] cur_addr_q, cur_addr_d;
    logic [LEN_WIDTH-1:0]  issue_cnt_q, issue_cnt_d;
    logic [LEN_WIDTH-1:0]  beat_cnt_q, beat_cnt_d;
    logic                  done_q, done_d;
    logic                  inflight_q;
    logic [1:0]            fill_q, fill_d;
    logic                  head_q;
    logic [WORD_WIDTH-1:0] buf_q [2];

    logic                  pop;
    logic                  issue;
    logic [2:0]            occ;

    assign pop = (fill_q != 2'd0) && out_ready_i;
    // Occupancy once this cycle's pop and capture settle; issue only if a slot stays free.
    assign occ = {1'b0, fill_q} + {2'b00, inflight_q} - {2'b00, pop};
    assign issue = (state_q == S_RUN) && (issue_cnt_q != '0) && (occ < 3'd2);
    assign fill_d = fill_q + {1'b0, inflight_q} - {1'b0, pop};

    always_comb begin
        state_d     = state_q;
        cur_addr_d  = cur_addr_q;
        issue_cnt_d = issue_cnt_q;
        beat_cnt_d  = beat_cnt_q;
        done_d      = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (cmd_valid_i) begin
                    cur_addr_d  = cmd_addr_i;
                    issue_cnt_d = cmd_len_i;
                    beat_cnt_d  = cmd_len_i;
                    if (cmd_len_i == '0) done_d = 1'b1;
                    else state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (issue) begin
                    if (cur_addr_q == ADDR_WIDTH'(WORD_COUNT - 1))
                        cur_addr_d = '0;
                    else
                        cur_addr_d = cur_addr_q + ADDR_WIDTH'(1);
                    issue_cnt_d = issue_cnt_q - LEN_WIDTH'(1);
                end
                if (pop) begin
                    beat_cnt_d = beat_cnt_q - LEN_WIDTH'(1);
                    if (beat_cnt_q == LEN_WIDTH'(1)) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q     <= S_IDLE;
            cur_addr_q  <= '0;
            issue_cnt_q <= '0;
            beat_cnt_q  <= '0;
            done_q      <= 1'b0;
            inflight_q  <= 1'b0;
            fill_q      <= 2'd0;
            head_q      <= 1'b0;
            buf_q[0]    <= '0;
            buf_q[1]    <= '0;
        end else begin
            state_q     <= state_d;
            cur_addr_q  <= cur_addr_d;
            issue_cnt_q <= issue_cnt_d;
            beat_cnt_q  <= beat_cnt_d;
            done_q      <= done_d;
            inflight_q  <= issue;
            fill_q      <= fill_d;
            // Tail slot is head + fill; the outstanding bound keeps fill <= 1 here.
            if (inflight_q) buf_q[head_q ^ fill_q[0]] <= ram_rdata_i;
            if (pop) head_q <= ~head_q;
        end
    end

    assign cmd_ready_o = (state_q == S_IDLE);
    assign busy_o      = (state_q != S_IDLE);
    assign done_o      = done_q;
    assign ram_addr_o  = cur_addr_q;
    assign out_valid_o = (fill_q != 2'd0);
    assign out_data_o  = buf_q[head_q];
    assign out_last_o  = out_valid_o && (beat_cnt_q == LEN_WIDTH'(1));

    a_cmd_known: assert property (@(posedge clk_i) disable iff (!rstn_i)
        cmd_valid_i |-> !$isunknown({cmd_addr_i, cmd_len_i}));
    a_cmd_len: assert property (@(posedge clk_i) disable iff (!rstn_i)
        cmd_valid_i |-> (cmd_len_i <= LEN_WIDTH'(WORD_COUNT)));
    a_out_stable: assert property (@(posedge clk_i) disable iff (!rstn_i)
        (out_valid_o && !out_ready_i) |=> ($stable(out_data_o) && $stable(out_last_o)));

endmodule

// File: tb/tb_ram_rd_streamer.sv
// Directed bench for ram_rd_streamer with a behavioural registered-read RAM.
// Each scenario task drives one command and checks beats cycle by cycle.
module tb_ram_rd_streamer;

    localparam int WW = 32;
    localparam int WC = 256;
    localparam int AW = 8;
    localparam int LW = 9;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [AW-1:0] cmd_addr = '0;
    logic [LW-1:0] cmd_len = '0;
    logic [AW-1:0] ram_addr;
    logic [WW-1:0] ram_rdata;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [WW-1:0] out_data;
    logic          out_last;
    logic          busy;
    logic          done;

    logic [WW-1:0] mem [WC];

    int pass_cnt = 0;
    int chk_cnt = 0;

    ram_rd_streamer #(.WORD_WIDTH(WW), .WORD_COUNT(WC)) dut (
        .clk_i(clk),
        .rstn_i(rstn),
        .cmd_valid_i(cmd_valid),
        .cmd_ready_o(cmd_ready),
        .cmd_addr_i(cmd_addr),
        .cmd_len_i(cmd_len),
        .ram_addr_o(ram_addr),
        .ram_rdata_i(ram_rdata),
        .out_valid_o(out_valid),
        .out_ready_i(out_ready),
        .out_data_o(out_data),
        .out_last_o(out_last),
        .busy_o(busy),
        .done_o(done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) ram_rdata <= mem[ram_addr];

    function automatic logic [WW-1:0] word(input int i);
        return 32'(i % WC) * 32'h01010101;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Handshake happens at the edge ending the current cycle; returns in T+1.
    task automatic send_cmd(input int a, input int l);
        cmd_valid = 1'b1;
        cmd_addr  = AW'(a);
        cmd_len   = LW'(l);
        chk_cnt++;
        if (cmd_ready !== 1'b1)
            $display("FAIL cmd_ready at send: got %b want 1", cmd_ready);
        else pass_cnt++;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        #12;
        chk_cnt++;
        if ({out_valid, out_last, busy, done, ram_addr, out_data} !== '0)
            $display("FAIL reset_outputs: got v=%b l=%b b=%b d=%b a=%h q=%h want all 0",
                     out_valid, out_last, busy, done, ram_addr, out_data);
        else pass_cnt++;
        chk_cnt++;
        if (cmd_ready !== 1'b1)
            $display("FAIL reset_cmd_ready: got %b want 1", cmd_ready);
        else pass_cnt++;
        @(posedge clk);
        #1 rstn = 1'b1;
        tick();
    endtask

    task automatic test_single();
        out_ready = 1'b1;
        send_cmd(5, 1);
        chk_cnt++;
        if (ram_addr !== 8'd5 || busy !== 1'b1)
            $display("FAIL single_T1: got addr=%0d busy=%b want 5 1", ram_addr, busy);
        else pass_cnt++;
        tick();
        chk_cnt++;
        if (out_valid !== 1'b0)
            $display("FAIL single_T2_valid: got %b want 0", out_valid);
        else pass_cnt++;
        tick();
        chk_cnt++;
        if (out_valid !== 1'b1 || out_data !== 32'h05050505 || out_last !== 1'b1)
            $display("FAIL single_T3: got v=%b d=%h l=%b want 1 05050505 1",
                     out_valid, out_data, out_last);
        else pass_cnt++;
        tick();
        chk_cnt++;
        if (done !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0)
            $display("FAIL single_T4: got done=%b v=%b busy=%b want 1 0 0", done, out_valid, busy);
        else pass_cnt++;
        tick();
        chk_cnt++;
        if (done !== 1'b0)
            $display("FAIL single_done_width: got %b want 0", done);
        else pass_cnt++;
    endtask

    task automatic run_full_rate(input string nm, input int a, input int n);
        send_cmd(a, n);
        tick();
        chk_cnt++;
        if (out_valid !== 1'b0)
            $display("FAIL %s_T2_valid: got %b want 0", nm, out_valid);
        else pass_cnt++;
        for (int i = 0; i < n; i++) begin
            tick();
            chk_cnt++;
            if (out_valid !== 1'b1 || out_data !== word(a + i) || out_last !== (i == n - 1))
                $display("FAIL %s_beat%0d: got v=%b d=%h l=%b want 1 %h %b",
                         nm, i, out_valid, out_data, out_last, word(a + i), i == n - 1);
            else pass_cnt++;
        end
        tick();
        chk_cnt++;
        if (done !== 1'b1 || out_valid !== 1'b0 || cmd_ready !== 1'b1)
            $display("FAIL %s_done: got done=%b v=%b rdy=%b want 1 0 1",
                     nm, done, out_valid, cmd_ready);
        else pass_cnt++;
    endtask

    task automatic test_burst();
        out_ready = 1'b1;
        run_full_rate("burst", 0, 16);
    endtask

    task automatic test_backpressure();
        logic [7:0]    pat = 8'b01101001;
        logic [WW-1:0] held_d;
        logic          held_l;
        logic          held = 1'b0;
        logic          seen_done = 1'b0;
        int            idx = 0;
        int            k = 0;
        send_cmd(40, 8);
        for (int c = 0; c < 200 && !seen_done; c++) begin
            if (held) begin
                chk_cnt++;
                if (out_valid !== 1'b1 || out_data !== held_d || out_last !== held_l)
                    $display("FAIL bp_hold: got v=%b d=%h l=%b want 1 %h %b",
                             out_valid, out_data, out_last, held_d, held_l);
                else pass_cnt++;
            end
            out_ready = pat[k % 8];
            k++;
            held = 1'b0;
            if (out_valid === 1'b1) begin
                if (out_ready) begin
                    chk_cnt++;
                    if (idx > 7 || out_data !== word(40 + idx) || out_last !== (idx == 7))
                        $display("FAIL bp_beat%0d: got d=%h l=%b want %h %b",
                                 idx, out_data, out_last, word(40 + idx), idx == 7);
                    else pass_cnt++;
                    idx++;
                end else begin
                    held   = 1'b1;
                    held_d = out_data;
                    held_l = out_last;
                end
            end
            tick();
            if (done === 1'b1) seen_done = 1'b1;
        end
        chk_cnt++;
        if (!seen_done || idx != 8)
            $display("FAIL bp_count: got beats=%0d done=%b want 8 1", idx, seen_done);
        else pass_cnt++;
        out_ready = 1'b1;
    endtask

    task automatic test_wrap_zero();
        out_ready = 1'b1;
        run_full_rate("wrap", 254, 4);
        send_cmd(0, 0);
        chk_cnt++;
        if (done !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0 || cmd_ready !== 1'b1)
            $display("FAIL zero_len: got done=%b busy=%b v=%b rdy=%b want 1 0 0 1",
                     done, busy, out_valid, cmd_ready);
        else pass_cnt++;
        tick();
        chk_cnt++;
        if (done !== 1'b0 || out_valid !== 1'b0)
            $display("FAIL zero_len_after: got done=%b v=%b want 0 0", done, out_valid);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        int   beats = 0;
        logic dn = 1'b0;
        out_ready = 1'b1;
        send_cmd(0, 32);
        for (int c = 0; c < 40 && beats < 10; c++) begin
            tick();
            if (out_valid === 1'b1) beats++;
        end
        chk_cnt++;
        if (beats != 10)
            $display("FAIL rst_mid_progress: got %0d beats want 10", beats);
        else pass_cnt++;
        #2 rstn = 1'b0;
        #1;
        chk_cnt++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || ram_addr !== 8'd0 || out_last !== 1'b0)
            $display("FAIL rst_mid_abort: got v=%b busy=%b a=%h l=%b want 0 0 00 0",
                     out_valid, busy, ram_addr, out_last);
        else pass_cnt++;
        for (int c = 0; c < 3; c++) begin
            tick();
            if (done !== 1'b0) dn = 1'b1;
        end
        rstn = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            if (done !== 1'b0) dn = 1'b1;
        end
        chk_cnt++;
        if (dn !== 1'b0)
            $display("FAIL rst_mid_no_done: got done pulse want none");
        else pass_cnt++;
        send_cmd(100, 2);
        tick();
        tick();
        chk_cnt++;
        if (out_valid !== 1'b1 || out_data !== 32'h64646464 || out_last !== 1'b0)
            $display("FAIL post_rst_beat0: got v=%b d=%h l=%b want 1 64646464 0",
                     out_valid, out_data, out_last);
        else pass_cnt++;
        tick();
        chk_cnt++;
        if (out_valid !== 1'b1 || out_data !== 32'h65656565 || out_last !== 1'b1)
            $display("FAIL post_rst_beat1: got v=%b d=%h l=%b want 1 65656565 1",
                     out_valid, out_data, out_last);
        else pass_cnt++;
        tick();
        chk_cnt++;
        if (done !== 1'b1)
            $display("FAIL post_rst_done: got %b want 1", done);
        else pass_cnt++;
    endtask

    initial begin
        for (int i = 0; i < WC; i++) mem[i] = 32'(i) * 32'h01010101;
        test_reset();
        test_single();
        test_burst();
        test_backpressure();
        test_wrap_zero();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
